// File: rtl/cpu_run_ctrl.sv
// Run controller between the board clock/reset source and the cpu core:
// sequences cpu reset and gates execution via a clock enable (free-run, budgeted, single-step).
module cpu_run_ctrl #(
  parameter int unsigned RST_CYCLES = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             soft_rst,
  input  logic             start,
  input  logic             step,
  input  logic             mode,
  input  logic [CNT_W-1:0] budget,
  input  logic             halt_req,
  output logic             cpu_reset,
  output logic             cpu_en,
  output logic             running,
  output logic             done,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int unsigned HW = $clog2(RST_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_CYCLES - 1);

  typedef enum logic [2:0] {
    S_RST_HOLD,
    S_IDLE,
    S_RUN,
    S_STEP,
    S_DONE
  } state_t;

  state_t           state, state_d;
  logic [HW-1:0]    hold_cnt, hold_d;
  logic [CNT_W-1:0] remaining, rem_d;
  logic [CNT_W-1:0] cnt_d, cnt_inc;
  logic             mode_r, mode_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_RST_HOLD;
      hold_cnt    <= '0;
      remaining   <= '0;
      cycle_count <= '0;
      mode_r      <= 1'b0;
    end else begin
      state       <= state_d;
      hold_cnt    <= hold_d;
      remaining   <= rem_d;
      cycle_count <= cnt_d;
      mode_r      <= mode_d;
    end
  end

  // Saturating increment: free-run keeps going once the counter is full.
  assign cnt_inc = (cycle_count == '1) ? cycle_count : cycle_count + CNT_W'(1);

  always_comb begin
    state_d = state;
    hold_d  = hold_cnt;
    rem_d   = remaining;
    cnt_d   = cycle_count;
    mode_d  = mode_r;
    if (soft_rst) begin
      state_d = S_RST_HOLD;
      hold_d  = '0;
      rem_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state)
        S_RST_HOLD: begin
          if (hold_cnt == HOLD_LAST) state_d = S_IDLE;
          else                       hold_d  = hold_cnt + HW'(1);
        end
        S_IDLE: begin
          if (start) begin
            mode_d  = mode;
            rem_d   = budget;
            state_d = (mode && budget == '0) ? S_DONE : S_RUN;
          end else if (step) begin
            state_d = S_STEP;
          end
        end
        S_RUN: begin
          cnt_d = cnt_inc;
          if (mode_r) rem_d = remaining - CNT_W'(1);
          // Halt and the final budgeted cycle both finish the run after counting this cycle.
          if (halt_req || (mode_r && remaining == CNT_W'(1))) state_d = S_DONE;
        end
        S_STEP: begin
          cnt_d   = cnt_inc;
          state_d = halt_req ? S_DONE : S_IDLE;
        end
        S_DONE: ;
        default: state_d = S_RST_HOLD;
      endcase
    end
  end

  assign cpu_reset = (state == S_RST_HOLD);
  assign cpu_en    = (state == S_RUN) || (state == S_STEP);
  assign running   = (state == S_RUN);
  assign done      = (state == S_DONE);

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: two instances (16-bit and 4-bit counters) checked every cycle
// against a behavioural model, plus directed scenarios with literal expectations.
module tb_cpu_run_ctrl;

  localparam int RSTC   = 2;
  localparam int P_HOLD = 0, P_IDLE = 1, P_RUN = 2, P_STEP = 3, P_DONE = 4;

  typedef struct {
    int ph;
    int hold;
    int rem;
    int cnt;
    bit md;
  } mdl_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0, soft_rst = 1'b0, start = 1'b0, step = 1'b0;
  logic        mode = 1'b0, halt_req = 1'b0;
  logic [15:0] budget = '0;

  logic        cpu_reset_w [2];
  logic        cpu_en_w    [2];
  logic        running_w   [2];
  logic        done_w      [2];
  logic [15:0] cc16;
  logic [3:0]  cc4;

  int   checks = 0, errors = 0, en_seen = 0;
  mdl_t m [2];
  int   mx [2] = '{65535, 15};

  always #5 clk = ~clk;

  cpu_run_ctrl #(.RST_CYCLES(RSTC), .CNT_W(16)) dut16 (
    .clk(clk), .reset(reset), .soft_rst(soft_rst), .start(start), .step(step),
    .mode(mode), .budget(budget), .halt_req(halt_req),
    .cpu_reset(cpu_reset_w[0]), .cpu_en(cpu_en_w[0]), .running(running_w[0]),
    .done(done_w[0]), .cycle_count(cc16)
  );

  cpu_run_ctrl #(.RST_CYCLES(RSTC), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .soft_rst(soft_rst), .start(start), .step(step),
    .mode(mode), .budget(budget[3:0]), .halt_req(halt_req),
    .cpu_reset(cpu_reset_w[1]), .cpu_en(cpu_en_w[1]), .running(running_w[1]),
    .done(done_w[1]), .cycle_count(cc4)
  );

  function automatic mdl_t m_reset();
    mdl_t r;
    r.ph = P_HOLD; r.hold = 0; r.rem = 0; r.cnt = 0; r.md = 1'b0;
    return r;
  endfunction

  function automatic mdl_t m_next(mdl_t s, int lim, bit sr, bit st, bit sp, bit md, int b, bit h);
    mdl_t n  = s;
    int   bb = b & lim;
    if (sr) begin
      n.ph = P_HOLD; n.hold = 0; n.cnt = 0; n.rem = 0;
      return n;
    end
    case (s.ph)
      P_HOLD: begin
        n.hold = s.hold + 1;
        if (n.hold >= RSTC) n.ph = P_IDLE;
      end
      P_IDLE: begin
        if (st) begin
          n.md  = md;
          n.rem = bb;
          n.ph  = (md && bb == 0) ? P_DONE : P_RUN;
        end else if (sp) n.ph = P_STEP;
      end
      P_RUN: begin
        n.cnt = (s.cnt < lim) ? s.cnt + 1 : lim;
        if (s.md) n.rem = s.rem - 1;
        if (h || (s.md && n.rem == 0)) n.ph = P_DONE;
      end
      P_STEP: begin
        n.cnt = (s.cnt < lim) ? s.cnt + 1 : lim;
        n.ph  = h ? P_DONE : P_IDLE;
      end
      default: ;
    endcase
    return n;
  endfunction

  always @(posedge clk)
    for (int i = 0; i < 2; i++)
      m[i] = !reset ? m_reset()
                    : m_next(m[i], mx[i], soft_rst, start, step, mode, int'(budget), halt_req);

  always @(negedge reset)
    for (int i = 0; i < 2; i++) m[i] = m_reset();

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0d expected %0d", nm, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cpu_en_w[0]) en_seen++;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("cpu_reset[%0d]", i), 32'(cpu_reset_w[i]), 32'(m[i].ph == P_HOLD));
      chk($sformatf("cpu_en[%0d]", i),    32'(cpu_en_w[i]),
          32'(m[i].ph == P_RUN || m[i].ph == P_STEP));
      chk($sformatf("running[%0d]", i),   32'(running_w[i]), 32'(m[i].ph == P_RUN));
      chk($sformatf("done[%0d]", i),      32'(done_w[i]),    32'(m[i].ph == P_DONE));
    end
    chk("cycle_count16", 32'(cc16), 32'(m[0].cnt));
    chk("cycle_count4",  32'(cc4),  32'(m[1].cnt));
  end

  task automatic wait_idle();
    for (int k = 0; k < 10 && cpu_reset_w[0]; k++) begin
      @(posedge clk); #1;
    end
    chk("wait_idle", 32'(cpu_reset_w[0]), 32'(0));
  endtask

  task automatic soft_reset_seq();
    @(negedge clk); soft_rst = 1'b1;
    @(negedge clk); soft_rst = 1'b0;
    wait_idle();
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  initial begin
    m[0] = m_reset();
    m[1] = m_reset();
    #1;
    chk("rst_cpu_reset", 32'(cpu_reset_w[0]), 32'(1));
    chk("rst_cpu_en",    32'(cpu_en_w[0]),    32'(0));
    chk("rst_count",     32'(cc16),           32'(0));

    // Reset release: cpu_reset held for exactly two edges
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    chk("t1_edge1_cpu_reset", 32'(cpu_reset_w[0]), 32'(1));
    @(posedge clk); #1;
    chk("t1_edge2_cpu_reset", 32'(cpu_reset_w[0]), 32'(0));
    chk("t1_idle_cpu_en",     32'(cpu_en_w[0]),    32'(0));

    // Budget of 20 cycles
    en_seen = 0;
    mode = 1'b1; budget = 16'd20;
    pulse_start();
    for (int k = 0; k < 60 && !done_w[0]; k++) begin
      @(posedge clk); #1;
    end
    chk("t2_done",      32'(done_w[0]), 32'(1));
    chk("t2_en_cycles", 32'(en_seen),   32'(20));
    chk("t2_count",     32'(cc16),      32'(20));
    chk("t2_model_cnt", 32'(m[0].cnt),  32'(20));

    // Halt during the 5th run cycle
    soft_reset_seq();
    en_seen = 0;
    pulse_start();
    repeat (4) @(negedge clk);
    halt_req = 1'b1;
    @(negedge clk) halt_req = 1'b0;
    @(posedge clk); #1;
    chk("t3_done",      32'(done_w[0]), 32'(1));
    chk("t3_en_cycles", 32'(en_seen),   32'(5));
    chk("t3_count",     32'(cc16),      32'(5));

    // Three single steps
    soft_reset_seq();
    en_seen = 0;
    repeat (3) begin
      @(negedge clk) step = 1'b1;
      @(negedge clk) step = 1'b0;
      @(negedge clk);
    end
    @(posedge clk); #1;
    chk("t4_en_cycles", 32'(en_seen),      32'(3));
    chk("t4_count",     32'(cc16),         32'(3));
    chk("t4_idle_en",   32'(cpu_en_w[0]),  32'(0));
    chk("t4_idle_done", 32'(done_w[0]),    32'(0));
    chk("t4_idle_run",  32'(running_w[0]), 32'(0));

    // Zero budget goes straight to DONE
    soft_reset_seq();
    en_seen = 0;
    mode = 1'b1; budget = 16'd0;
    pulse_start();
    #1 chk("t5_zero_done", 32'(done_w[0]), 32'(1));
    repeat (3) @(posedge clk);
    #1 chk("t5_zero_en", 32'(en_seen), 32'(0));

    // start and step together: start wins
    soft_reset_seq();
    mode = 1'b0;
    @(negedge clk) begin start = 1'b1; step = 1'b1; end
    @(negedge clk) begin start = 1'b0; step = 1'b0; end
    #1 chk("t5_both_running", 32'(running_w[0]), 32'(1));

    // Asynchronous reset mid-run, no clock edge
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("t6_async_cpu_reset", 32'(cpu_reset_w[0]), 32'(1));
    chk("t6_async_cpu_en",    32'(cpu_en_w[0]),    32'(0));
    chk("t6_async_count",     32'(cc16),           32'(0));
    @(negedge clk) reset = 1'b1;
    wait_idle();

    // Free run 20 cycles: 4-bit counter saturates at 15
    en_seen = 0;
    mode = 1'b0;
    pulse_start();
    repeat (19) @(negedge clk);
    halt_req = 1'b1;
    @(negedge clk) halt_req = 1'b0;
    @(posedge clk); #1;
    chk("t6_sat_done",   32'(done_w[0]), 32'(1));
    chk("t6_sat_en",     32'(en_seen),   32'(20));
    chk("t6_sat_cnt16",  32'(cc16),      32'(20));
    chk("t6_sat_cnt4",   32'(cc4),       32'(15));

    // soft_rst out of DONE
    @(negedge clk) soft_rst = 1'b1;
    @(negedge clk) soft_rst = 1'b0;
    #1;
    chk("t6_soft_cpu_reset", 32'(cpu_reset_w[0]), 32'(1));
    chk("t6_soft_count",     32'(cc16),           32'(0));
    chk("t6_soft_done",      32'(done_w[0]),      32'(0));
    wait_idle();

    // Randomized traffic against the model
    repeat (3000) begin
      @(negedge clk); #1;
      reset    = ($urandom_range(0, 199) != 0);
      soft_rst = ($urandom_range(0, 49) == 0);
      start    = ($urandom_range(0, 7) == 0);
      step     = ($urandom_range(0, 7) == 0);
      mode     = 1'($urandom_range(0, 1));
      budget   = 16'($urandom_range(0, 24));
      halt_req = ($urandom_range(0, 19) == 0);
    end
    @(negedge clk); #1;
    reset = 1'b1; soft_rst = 1'b0; start = 1'b0; step = 1'b0; halt_req = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
